switch_trigger_conditioner: RTL and testbench

Conditions a raw, asynchronous, bouncing cabinet switch (coin, serve, start) into a clean active-low trigger pulse. It sits directly upstream of the 555 monostable oneshot emulation and drives that block's TRG_N input. It also supplies a debounced level for game logic. All timing is counted in CLK cycles.

---
 rtl/switch_trigger_conditioner.sv | 117 +++++++++++
 tb/tb_switch_trigger_conditioner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_trigger_conditioner.sv
// Turns a raw, bouncing cabinet switch into a debounced level (PRESSED) and a
// fixed-length active-low trigger pulse (TRG_N) for the downstream oneshot.
module switch_trigger_conditioner #(
    parameter int DEBOUNCE_COUNTS = 1000,
    parameter int PULSE_COUNTS    = 4,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SW_IN,
    output logic TRG_N,
    output logic PRESSED
);

    localparam int CW = $clog2(DEBOUNCE_COUNTS + 1);
    localparam int PW = $clog2(PULSE_COUNTS + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_COUNTS - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_COUNTS - 1);
    localparam logic IDLE_LEVEL = ACTIVE_LOW;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pcnt;
    logic          s1;
    logic          s2;
    logic          act;
    logic          start;

    // Two-flop synchronizer; reset parks it at the open-switch level so no
    // phantom press is seen when reset releases.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1 <= IDLE_LEVEL;
            s2 <= IDLE_LEVEL;
        end else begin
            s1 <= SW_IN;
            s2 <= s1;
        end
    end

    assign act   = ACTIVE_LOW ? ~s2 : s2;
    assign start = (state == PRESS_WAIT) && act && (cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= RELEASED;
            cnt     <= '0;
            PRESSED <= 1'b0;
        end else begin
            case (state)
                RELEASED: begin
                    if (act) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!act) begin
                        state <= RELEASED;
                    end else if (cnt == CNT_LAST) begin
                        state   <= HELD;
                        PRESSED <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!act) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                // A bounce back to closed resumes HELD without a new pulse.
                RELEASE_WAIT: begin
                    if (act) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state   <= RELEASED;
                        PRESSED <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= RELEASED;
                    cnt     <= '0;
                    PRESSED <= 1'b0;
                end
            endcase
        end
    end

    // Non-retriggerable: a start while the pulse is running is ignored.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            TRG_N <= 1'b1;
            pcnt  <= '0;
        end else if (!TRG_N) begin
            if (pcnt == '0) begin
                TRG_N <= 1'b1;
            end else begin
                pcnt <= pcnt - PW'(1);
            end
        end else if (start) begin
            TRG_N <= 1'b0;
            pcnt  <= PULSE_LAST;
        end
    end

endmodule

// File: tb/tb_switch_trigger_conditioner.sv
// Scoreboard bench: stimulus queues expected output changes (cycle + values),
// a monitor pops one entry whenever a DUT output pair changes.
module tb_switch_trigger_conditioner;

    logic       CLK;
    logic [2:0] rst;
    logic [2:0] sw;
    logic [2:0] trg;
    logic [2:0] pr;
    logic [2:0] rst_seen;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit free_run = 1'b0;
    int pulses = 0;
    int presses = 0;
    int low_len = 0;

    typedef struct packed {
        int   dut;
        int   cyc;
        logic trg;
        logic pr;
    } exp_t;

    exp_t exp_q[$];

    // dut 0: D=4 P=2 active-low, dut 1: D=4 P=3 active-low, dut 2: D=1 P=1 active-high
    switch_trigger_conditioner #(.DEBOUNCE_COUNTS(4), .PULSE_COUNTS(2), .ACTIVE_LOW(1'b1)) dut_a (
        .CLK(CLK), .RESET(rst[0]), .SW_IN(sw[0]), .TRG_N(trg[0]), .PRESSED(pr[0]));
    switch_trigger_conditioner #(.DEBOUNCE_COUNTS(4), .PULSE_COUNTS(3), .ACTIVE_LOW(1'b1)) dut_b (
        .CLK(CLK), .RESET(rst[1]), .SW_IN(sw[1]), .TRG_N(trg[1]), .PRESSED(pr[1]));
    switch_trigger_conditioner #(.DEBOUNCE_COUNTS(1), .PULSE_COUNTS(1), .ACTIVE_LOW(1'b0)) dut_c (
        .CLK(CLK), .RESET(rst[2]), .SW_IN(sw[2]), .TRG_N(trg[2]), .PRESSED(pr[2]));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        cyc      = cyc + 1;
        rst_seen = rst;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic apply_stimulus(input int d, input logic level, output int base);
        sw[d] = level;
        base  = cyc;
    endtask

    task automatic expect_event(input int d, input int at, input logic t, input logic p);
        exp_t e;
        e.dut = d;
        e.cyc = at;
        e.trg = t;
        e.pr  = p;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string name, input int d, input logic t, input logic p);
        n_checks++;
        if (trg[d] !== t || pr[d] !== p) begin
            n_errors++;
            $display("[TB] FAIL %s: dut%0d TRG_N=%b PRESSED=%b, expected TRG_N=%b PRESSED=%b",
                     name, d, trg[d], pr[d], t, p);
        end
    endtask

    // Monitor
    initial begin
        logic [1:0] prev [3];
        logic [1:0] cur;
        exp_t e;
        for (int d = 0; d < 3; d++) prev[d] = 2'b10;
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            for (int d = 0; d < 3; d++) begin
                cur = {trg[d], pr[d]};
                if (rst_seen[d]) begin
                    n_checks++;
                    if (trg[d] !== 1'b1) begin
                        n_errors++;
                        $display("[TB] FAIL trg_in_reset: dut%0d cycle %0d TRG_N=%b, expected 1", d, cyc, trg[d]);
                    end
                end
                if (free_run && d == 0) begin
                    if (cur[1] == 1'b0) low_len++;
                    if (prev[0][1] == 1'b1 && cur[1] == 1'b0) pulses++;
                    if (prev[0][0] == 1'b0 && cur[0] == 1'b1) presses++;
                    if (prev[0][1] == 1'b0 && cur[1] == 1'b1) begin
                        n_checks++;
                        if (low_len != 2) begin
                            n_errors++;
                            $display("[TB] FAIL pulse_len: cycle %0d low for %0d cycles, expected 2", cyc, low_len);
                        end
                        low_len = 0;
                    end
                end else if (cur !== prev[d]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("[TB] FAIL unexpected_change: dut%0d cycle %0d TRG_N=%b PRESSED=%b, expected no change",
                                 d, cyc, cur[1], cur[0]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.dut != d || e.cyc != cyc || e.trg !== cur[1] || e.pr !== cur[0]) begin
                            n_errors++;
                            $display("[TB] FAIL event: got dut%0d cycle %0d TRG_N=%b PRESSED=%b, expected dut%0d cycle %0d TRG_N=%b PRESSED=%b",
                                     d, cyc, cur[1], cur[0], e.dut, e.cyc, e.trg, e.pr);
                        end
                    end
                end
                prev[d] = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int b;
        int dly;
        rst = 3'b111;
        sw  = 3'b011;
        wait_cycles(3);
        for (int d = 0; d < 3; d++) check_output("reset_state", d, 1'b1, 1'b0);
        rst = 3'b000;
        wait_cycles(3);

        // Clean press on dut0: HELD after E7, pulse 2 cycles.
        $display("[TB] clean press");
        apply_stimulus(0, 1'b0, b);
        expect_event(0, b + 7, 1'b0, 1'b1);
        expect_event(0, b + 9, 1'b1, 1'b1);
        wait_cycles(12);
        check_output("held_level", 0, 1'b1, 1'b1);
        apply_stimulus(0, 1'b1, b);
        expect_event(0, b + 7, 1'b1, 1'b0);
        wait_cycles(10);

        // Short presses never reach D consecutive active cycles.
        $display("[TB] glitch rejection");
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 1'b0, b);
            wait_cycles(3);
            apply_stimulus(0, 1'b1, b);
            wait_cycles(3);
        end
        wait_cycles(8);
        check_output("glitch_idle", 0, 1'b1, 1'b0);

        // Short release while held, then full release and re-press.
        $display("[TB] release bounce");
        apply_stimulus(0, 1'b0, b);
        expect_event(0, b + 7, 1'b0, 1'b1);
        expect_event(0, b + 9, 1'b1, 1'b1);
        wait_cycles(12);
        apply_stimulus(0, 1'b1, b);
        wait_cycles(2);
        apply_stimulus(0, 1'b0, b);
        wait_cycles(8);
        check_output("bounce_held", 0, 1'b1, 1'b1);
        apply_stimulus(0, 1'b1, b);
        expect_event(0, b + 7, 1'b1, 1'b0);
        wait_cycles(10);
        apply_stimulus(0, 1'b0, b);
        expect_event(0, b + 7, 1'b0, 1'b1);
        expect_event(0, b + 9, 1'b1, 1'b1);
        wait_cycles(12);
        apply_stimulus(0, 1'b1, b);
        expect_event(0, b + 7, 1'b1, 1'b0);
        wait_cycles(10);

        // Reset during second low cycle of a 3-cycle pulse on dut1.
        $display("[TB] reset mid-pulse");
        apply_stimulus(1, 1'b0, b);
        expect_event(1, b + 7, 1'b0, 1'b1);
        wait_cycles(8);
        rst[1] = 1'b1;
        expect_event(1, b + 9, 1'b1, 1'b0);
        wait_cycles(2);
        rst[1] = 1'b0;
        b = cyc;
        expect_event(1, b + 7, 1'b0, 1'b1);
        expect_event(1, b + 10, 1'b1, 1'b1);
        wait_cycles(14);
        apply_stimulus(1, 1'b1, b);
        expect_event(1, b + 7, 1'b1, 1'b0);
        wait_cycles(10);

        // Active-high input, D=1, P=1 on dut2.
        $display("[TB] active-high minimal");
        apply_stimulus(2, 1'b1, b);
        expect_event(2, b + 4, 1'b0, 1'b1);
        expect_event(2, b + 5, 1'b1, 1'b1);
        wait_cycles(8);
        apply_stimulus(2, 1'b0, b);
        expect_event(2, b + 4, 1'b1, 1'b0);
        wait_cycles(8);

        // Asynchronous bouncing presses on dut0.
        $display("[TB] free-running bouncy presses");
        free_run = 1'b1;
        for (int p = 0; p < 10; p++) begin
            repeat ($urandom_range(5, 2)) begin
                sw[0] = 1'b0;
                dly = $urandom_range(15, 2);
                #dly;
                sw[0] = 1'b1;
                dly = $urandom_range(40, 20);
                #dly;
            end
            sw[0] = 1'b0;
            dly = $urandom_range(200, 150);
            #dly;
            repeat ($urandom_range(4, 2)) begin
                sw[0] = 1'b1;
                dly = $urandom_range(15, 2);
                #dly;
                sw[0] = 1'b0;
                dly = $urandom_range(40, 20);
                #dly;
            end
            repeat ($urandom_range(4, 2)) begin
                sw[0] = 1'b1;
                dly = $urandom_range(15, 2);
                #dly;
                sw[0] = 1'b0;
                dly = $urandom_range(15, 2);
                #dly;
            end
            sw[0] = 1'b1;
            dly = $urandom_range(200, 150);
            #dly;
        end
        wait_cycles(20);
        free_run = 1'b0;

        n_checks++;
        if (pulses != 10) begin
            n_errors++;
            $display("[TB] FAIL pulse_count: got %0d pulses, expected 10", pulses);
        end
        n_checks++;
        if (presses != 10) begin
            n_errors++;
            $display("[TB] FAIL press_count: got %0d presses, expected 10", presses);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("[TB] FAIL missing_events: %0d expected events never seen, expected 0", exp_q.size());
        end
        for (int d = 0; d < 3; d++) check_output("final_idle", d, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
